// File: rtl/pipe_pkg.sv
// Shared MEM-stage types: access FSM state, the MEM/WB bundle and its bubble value.
package pipe_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic        regdst;
    logic        regwrite;
    logic [1:0]  memtoreg;
    logic [3:0]  reg_dest;
    logic [15:0] alu_result;
    logic [15:0] mem_data;
  } wb_t;

  localparam wb_t WB_BUBBLE = '0;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus: stage drives a held request, memory answers with a one-cycle ack.
// No backpressure beyond ack itself; rdata is only meaningful in the ack cycle.
interface mem_access_stage_if;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        ack;
  logic [15:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_timeout_ctr.sv
// Counts cycles of an outstanding access; expired is combinational when the count hits TIMEOUT_CYCLES-1.
// No handshake: clr wins over en, and TIMEOUT_CYCLES=0 keeps expired low forever.
module mem_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam bit          TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [15:0] LAST  = TO_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'hFFFF;

  logic [15:0] cnt_q;

  // Saturate so a disabled timeout can never wrap into a false expiry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign expired = TO_EN && (cnt_q == LAST);

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage + MEM/WB register: non-mem ops latency 1; loads/stores 1 cycle to req plus ack delay, with timeout.
// Backpressure: mem_stall holds EX/MEM while an access is outstanding. MEM_STALL_CNT_EN adds stall_cycles.
module mem_access_stage
  import pipe_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [15:0] ERR_RDATA      = 16'h0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                regdst_in,
  input  logic                regwrite_in,
  input  logic [1:0]          memtoreg_in,
  input  logic                memread_in,
  input  logic                memwrite_in,
  input  logic [15:0]         alu_out_in,
  input  logic [15:0]         alu_src2_in,
  input  logic [3:0]          reg_source_in,
  output logic                mem_stall,
  mem_access_stage_if.master  dmem,
  output logic                wb_regdst,
  output logic                wb_regwrite,
  output logic [1:0]          wb_memtoreg,
  output logic [3:0]          wb_reg_dest,
  output logic [15:0]         wb_alu_result,
  output logic [15:0]         wb_mem_data,
  output logic                dmem_err
`ifdef MEM_STALL_CNT_EN
  ,
  output logic [15:0]         stall_cycles
`endif
);

  state_t state_q, state_d;
  wb_t    wb_q, wb_d, cap_q, ex_fields;
  logic   is_load_q, err_d, err_q;
  logic   mem_op, done, capture, expired;

  assign mem_op    = memread_in | memwrite_in;
  assign ex_fields = '{regdst: regdst_in, regwrite: regwrite_in, memtoreg: memtoreg_in,
                       reg_dest: reg_source_in, alu_result: alu_out_in, mem_data: 16'h0000};

  mem_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     ((state_q != BUSY) | done),
    .en      ((state_q == BUSY) & ~done),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mem_stall = 1'b0;
    done      = 1'b0;
    capture   = 1'b0;
    err_d     = 1'b0;
    wb_d      = WB_BUBBLE;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          mem_stall = 1'b1;
          capture   = 1'b1;
          state_d   = BUSY;
        end else begin
          wb_d = ex_fields;
        end
      end
      BUSY: begin
        // A real ack takes precedence over a timeout landing in the same cycle.
        done      = dmem.ack | expired;
        mem_stall = ~done;
        if (done) begin
          state_d = IDLE;
          wb_d    = cap_q;
          if (dmem.ack) begin
            if (is_load_q) wb_d.mem_data = dmem.rdata;
          end else begin
            err_d = 1'b1;
            if (is_load_q) begin
              wb_d.mem_data = ERR_RDATA;
              wb_d.regwrite = 1'b0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dmem.req   <= 1'b0;
      dmem.we    <= 1'b0;
      dmem.addr  <= 16'h0000;
      dmem.wdata <= 16'h0000;
      cap_q      <= WB_BUBBLE;
      is_load_q  <= 1'b0;
      wb_q       <= WB_BUBBLE;
      err_q      <= 1'b0;
    end else begin
      wb_q  <= wb_d;
      err_q <= err_d;
      if (capture) begin
        dmem.req   <= 1'b1;
        dmem.we    <= memwrite_in;
        dmem.addr  <= alu_out_in;
        dmem.wdata <= alu_src2_in;
        cap_q      <= ex_fields;
        is_load_q  <= ~memwrite_in;
      end else if (done) begin
        dmem.req <= 1'b0;
      end
    end
  end

  assign wb_regdst     = wb_q.regdst;
  assign wb_regwrite   = wb_q.regwrite;
  assign wb_memtoreg   = wb_q.memtoreg;
  assign wb_reg_dest   = wb_q.reg_dest;
  assign wb_alu_result = wb_q.alu_result;
  assign wb_mem_data   = wb_q.mem_data;
  assign dmem_err      = err_q;

`ifdef MEM_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= 16'h0000;
    end else if (mem_stall && stall_cycles != 16'hFFFF) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule
